// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side initiator for the UART command protocol.
// Takes one command per Cmd_valid/Cmd_ready handshake, serializes its frame
// bytes onto a UART TX byte interface, and for reads/ALU commands collects the
// response bytes from a UART RX byte interface before reporting completion.
//
// Optional build macro: UART_CMD_MASTER_WR_VERIFY_EN
//   When defined, every register write is followed automatically by a read of
//   the same address; the read-back byte is returned and Rsp_mismatch flags a
//   difference from the written data.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   Cmd_*           command request (type, addr, wdata/opA, opB, fun)
//   TX_data/valid   frame byte towards UART TX, TX_ready backpressure
//   RX_data/valid   response byte pulse from UART RX
//   Rsp_valid       one-cycle completion pulse with Rsp_data/Rsp_timeout
//   Rsp_mismatch    write-verify miscompare (only with the macro defined)
module uart_cmd_master #(
  parameter int unsigned Data_width     = 8,
  parameter int unsigned Address_width  = 4,
  parameter int unsigned Alu_rsp_bytes  = 2,
  parameter int unsigned Timeout_cycles = 65535
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      Cmd_valid,
  output logic                      Cmd_ready,
  input  logic [1:0]                Cmd_type,
  input  logic [Address_width-1:0]  Cmd_addr,
  input  logic [Data_width-1:0]     Cmd_wdata,
  input  logic [Data_width-1:0]     Cmd_opb,
  input  logic [3:0]                Cmd_fun,
  output logic [Data_width-1:0]     TX_data,
  output logic                      TX_valid,
  input  logic                      TX_ready,
  input  logic [Data_width-1:0]     RX_data,
  input  logic                      RX_valid,
  output logic                      Rsp_valid,
  output logic [2*Data_width-1:0]   Rsp_data,
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
  output logic                      Rsp_mismatch,
`endif
  output logic                      Rsp_timeout
);

  localparam int unsigned TMO_W = (Timeout_cycles < 2) ? 1 : $clog2(Timeout_cycles + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(Timeout_cycles);

  localparam logic [Data_width-1:0] CODE_WR  = Data_width'(8'hAA);
  localparam logic [Data_width-1:0] CODE_RD  = Data_width'(8'hBB);
  localparam logic [Data_width-1:0] CODE_ALU = Data_width'(8'hCC);
  localparam logic [Data_width-1:0] CODE_FUN = Data_width'(8'hDD);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [Data_width-1:0]   buf_q [4];
  logic [Data_width-1:0]   buf_d [4];
  logic [1:0]              idx_q, idx_d;
  logic [1:0]              last_q, last_d;
  logic [1:0]              rx_need_q, rx_need_d;
  logic [1:0]              rx_cnt_q, rx_cnt_d;
  logic [Data_width-1:0]   rx_byte_q [2];
  logic [Data_width-1:0]   rx_byte_d [2];
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic                    tmo_flag_q, tmo_flag_d;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [Data_width-1:0]   tx_data_q, tx_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [2*Data_width-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_timeout_q, rsp_timeout_d;

`ifdef UART_CMD_MASTER_WR_VERIFY_EN
  logic                    verify_q, verify_d;
  logic                    rsp_mismatch_q, rsp_mismatch_d;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    last_d     = last_q;
    rx_need_d  = rx_need_q;
    rx_cnt_d   = rx_cnt_q;
    rx_byte_d  = rx_byte_q;
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    verify_d   = verify_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Cmd_valid) begin
          state_d    = SEND;
          idx_d      = 2'd0;
          rx_cnt_d   = 2'd0;
          rx_byte_d  = '{default: '0};
          tmo_d      = TMO_LOAD;
          tmo_flag_d = 1'b0;
          buf_d      = '{default: '0};
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
          verify_d   = 1'b0;
`endif
          unique case (Cmd_type)
            2'd0: begin
              buf_d[0]  = CODE_WR;
              buf_d[1]  = Data_width'(Cmd_addr);
              buf_d[2]  = Cmd_wdata;
              last_d    = 2'd2;
              rx_need_d = 2'd0;
            end
            2'd1: begin
              buf_d[0]  = CODE_RD;
              buf_d[1]  = Data_width'(Cmd_addr);
              last_d    = 2'd1;
              rx_need_d = 2'd1;
            end
            2'd2: begin
              buf_d[0]  = CODE_ALU;
              buf_d[1]  = Cmd_wdata;
              buf_d[2]  = Cmd_opb;
              buf_d[3]  = Data_width'(Cmd_fun);
              last_d    = 2'd3;
              rx_need_d = 2'(Alu_rsp_bytes);
            end
            2'd3: begin
              buf_d[0]  = CODE_FUN;
              buf_d[1]  = Data_width'(Cmd_fun);
              last_d    = 2'd1;
              rx_need_d = 2'(Alu_rsp_bytes);
            end
          endcase
        end
      end

      SEND: begin
        if (tx_valid_q && TX_ready) begin
          if (idx_q == last_q) begin
            if (rx_need_q == 2'd0) begin
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
              // Reuse the buffer for the read-back frame; addr stays in [1], wdata in [2]
              buf_d[0]  = CODE_RD;
              idx_d     = 2'd0;
              last_d    = 2'd1;
              rx_need_d = 2'd1;
              verify_d  = 1'b1;
`else
              state_d   = DONE;
`endif
            end else begin
              state_d  = WAIT_RSP;
              rx_cnt_d = 2'd0;
              tmo_d    = TMO_LOAD;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      WAIT_RSP: begin
        // A byte arriving on the expiry cycle is accepted and reloads the timer
        if (RX_valid) begin
          rx_byte_d[rx_cnt_q[0]] = RX_data;
          rx_cnt_d = rx_cnt_q + 2'd1;
          tmo_d    = TMO_LOAD;
          if (rx_cnt_q == (rx_need_q - 2'd1)) begin
            state_d = DONE;
          end
        end else if (tmo_q <= TMO_W'(1)) begin
          state_d    = DONE;
          tmo_flag_d = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next-state view so they align with state_q
    cmd_ready_d   = (state_d == IDLE);
    tx_valid_d    = (state_d == SEND);
    tx_data_d     = tx_valid_d ? buf_d[idx_d] : '0;
    rsp_valid_d   = (state_d == DONE);
    rsp_data_d    = (rsp_valid_d && !tmo_flag_d) ? {rx_byte_d[1], rx_byte_d[0]} : '0;
    rsp_timeout_d = rsp_valid_d && tmo_flag_d;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    rsp_mismatch_d = rsp_valid_d && verify_d && !tmo_flag_d && (rx_byte_d[0] != buf_d[2]);
`endif
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= IDLE;
      buf_q         <= '{default: '0};
      idx_q         <= 2'd0;
      last_q        <= 2'd0;
      rx_need_q     <= 2'd0;
      rx_cnt_q      <= 2'd0;
      rx_byte_q     <= '{default: '0};
      tmo_q         <= '0;
      tmo_flag_q    <= 1'b0;
      cmd_ready_q   <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
      verify_q       <= 1'b0;
      rsp_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      rx_need_q     <= rx_need_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_byte_q     <= rx_byte_d;
      tmo_q         <= tmo_d;
      tmo_flag_q    <= tmo_flag_d;
      cmd_ready_q   <= cmd_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
      verify_q       <= verify_d;
      rsp_mismatch_q <= rsp_mismatch_d;
`endif
    end
  end

  assign Cmd_ready   = cmd_ready_q;
  assign TX_valid    = tx_valid_q;
  assign TX_data     = tx_data_q;
  assign Rsp_valid   = rsp_valid_q;
  assign Rsp_data    = rsp_data_q;
  assign Rsp_timeout = rsp_timeout_q;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
  assign Rsp_mismatch = rsp_mismatch_q;
`endif

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed testbench for uart_cmd_master (Timeout_cycles reduced to 20).
module tb_uart_cmd_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Cmd_valid;
  logic        Cmd_ready;
  logic [1:0]  Cmd_type;
  logic [3:0]  Cmd_addr;
  logic [7:0]  Cmd_wdata;
  logic [7:0]  Cmd_opb;
  logic [3:0]  Cmd_fun;
  logic [7:0]  TX_data;
  logic        TX_valid;
  logic        TX_ready;
  logic [7:0]  RX_data;
  logic        RX_valid;
  logic        Rsp_valid;
  logic [15:0] Rsp_data;
  logic        Rsp_timeout;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
  logic        Rsp_mismatch;
`endif

  always #5 CLK = ~CLK;

  uart_cmd_master #(
    .Data_width     (8),
    .Address_width  (4),
    .Alu_rsp_bytes  (2),
    .Timeout_cycles (20)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Cmd_valid   (Cmd_valid),
    .Cmd_ready   (Cmd_ready),
    .Cmd_type    (Cmd_type),
    .Cmd_addr    (Cmd_addr),
    .Cmd_wdata   (Cmd_wdata),
    .Cmd_opb     (Cmd_opb),
    .Cmd_fun     (Cmd_fun),
    .TX_data     (TX_data),
    .TX_valid    (TX_valid),
    .TX_ready    (TX_ready),
    .RX_data     (RX_data),
    .RX_valid    (RX_valid),
    .Rsp_valid   (Rsp_valid),
    .Rsp_data    (Rsp_data),
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    .Rsp_mismatch(Rsp_mismatch),
`endif
    .Rsp_timeout (Rsp_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0]  tx_q [$];
  int          tx_cyc [$];
  int          rsp_cnt   = 0;
  logic [15:0] rsp_data_l;
  logic        rsp_tmo_l;
  logic        rsp_mm_l;
  int          rsp_cyc_l = 0;
  int          rx_cyc_l  = 0;
  int          n0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record transfers mid-cycle, away from the clock edge
  always @(negedge CLK) begin
    if (TX_valid && TX_ready) begin
      tx_q.push_back(TX_data);
      tx_cyc.push_back(cyc);
    end
    if (RX_valid) rx_cyc_l = cyc;
    if (Rsp_valid) begin
      rsp_cnt    = rsp_cnt + 1;
      rsp_data_l = Rsp_data;
      rsp_tmo_l  = Rsp_timeout;
      rsp_cyc_l  = cyc;
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
      rsp_mm_l   = Rsp_mismatch;
`else
      rsp_mm_l   = 1'b0;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] txb(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  function automatic int txc(input int i);
    if (i < tx_cyc.size()) return tx_cyc[i];
    return -1000;
  endfunction

  task automatic clr();
    tx_q.delete();
    tx_cyc.delete();
  endtask

  // Present a command for one cycle, then scramble the fields to prove they were latched
  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] w,
                       input logic [7:0] b, input logic [3:0] f);
    Cmd_type  = t;
    Cmd_addr  = a;
    Cmd_wdata = w;
    Cmd_opb   = b;
    Cmd_fun   = f;
    Cmd_valid = 1'b1;
    step();
    Cmd_valid = 1'b0;
    Cmd_type  = ~t;
    Cmd_addr  = ~a;
    Cmd_wdata = ~w;
    Cmd_opb   = ~b;
    Cmd_fun   = ~f;
  endtask

  task automatic send_rx(input logic [7:0] d);
    RX_data  = d;
    RX_valid = 1'b1;
    step();
    RX_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 100) begin
      step();
      k++;
    end
    check(tag, tx_q.size(), n);
  endtask

  task automatic wait_rsp(input int base, input string tag);
    int k = 0;
    while (rsp_cnt == base && k < 100) begin
      step();
      k++;
    end
    check(tag, rsp_cnt - base, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; Cmd_valid = 1'b0; Cmd_type = '0; Cmd_addr = '0; Cmd_wdata = '0;
    Cmd_opb = '0; Cmd_fun = '0; TX_ready = 1'b1; RX_data = '0; RX_valid = 1'b0;
    step();
    step();
    check("rst_cmd_ready", Cmd_ready, 1);
    check("rst_tx_valid", TX_valid, 0);
    check("rst_rsp_valid", Rsp_valid, 0);
    check("rst_rsp_data", Rsp_data, 0);
    check("rst_rsp_tmo", Rsp_timeout, 0);
    RST = 1'b0;
    step();

    // Write addr 5 data AB, TX always ready
    clr(); n0 = rsp_cnt;
    issue(2'd0, 4'd5, 8'hAB, 8'h00, 4'd0);
    check("wr_busy", Cmd_ready, 0);
    check("wr_b0_now", TX_data, 8'hAA);
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    wait_tx(5, "wr_tx_cnt");
    step();
    send_rx(8'hAB);
`endif
    wait_rsp(n0, "wr_rsp");
    check("wr_b0", txb(0), 8'hAA);
    check("wr_b1", txb(1), 8'h05);
    check("wr_b2", txb(2), 8'hAB);
    check("wr_b2b", txc(2) - txc(0), 2);
`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    check("wr_vb0", txb(3), 8'hBB);
    check("wr_vb1", txb(4), 8'h05);
    check("wr_lat", rsp_cyc_l - rx_cyc_l, 1);
    check("wr_data", rsp_data_l, 16'h00AB);
    check("wr_mm", rsp_mm_l, 0);
`else
    check("wr_lat", rsp_cyc_l - txc(2), 1);
    check("wr_data", rsp_data_l, 16'h0000);
`endif
    check("wr_tmo", rsp_tmo_l, 0);
    step();

    // Read addr 5 with a 3-cycle stall on the address byte and a stray RX byte
    clr(); n0 = rsp_cnt;
    issue(2'd1, 4'd5, 8'h00, 8'h00, 4'd0);
    step();
    check("rd_b1_show", TX_data, 8'h05);
    TX_ready = 1'b0;
    RX_data  = 8'h77;
    RX_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      RX_valid = 1'b0;
      check("rd_stall_valid", TX_valid, 1);
      check("rd_stall_data", TX_data, 8'h05);
    end
    TX_ready = 1'b1;
    wait_tx(2, "rd_tx_cnt");
    step();
    step();
    send_rx(8'hAB);
    wait_rsp(n0, "rd_rsp");
    check("rd_b0", txb(0), 8'hBB);
    check("rd_b1", txb(1), 8'h05);
    check("rd_data", rsp_data_l, 16'h00AB);
    check("rd_tmo", rsp_tmo_l, 0);
    check("rd_lat", rsp_cyc_l - rx_cyc_l, 1);
    step();

    // ALU with operands
    clr(); n0 = rsp_cnt;
    issue(2'd2, 4'd0, 8'h10, 8'h25, 4'd0);
    wait_tx(4, "alu_tx_cnt");
    send_rx(8'h35);
    step();
    send_rx(8'h00);
    wait_rsp(n0, "alu_rsp");
    check("alu_b0", txb(0), 8'hCC);
    check("alu_b1", txb(1), 8'h10);
    check("alu_b2", txb(2), 8'h25);
    check("alu_b3", txb(3), 8'h00);
    check("alu_b2b", txc(3) - txc(0), 3);
    check("alu_data", rsp_data_l, 16'h0035);
    check("alu_tmo", rsp_tmo_l, 0);
    check("alu_lat", rsp_cyc_l - rx_cyc_l, 1);
    step();

    // ALU without operand, second response byte never arrives
    clr(); n0 = rsp_cnt;
    issue(2'd3, 4'd0, 8'h00, 8'h00, 4'd9);
    wait_tx(2, "fun_tx_cnt");
    step();
    send_rx(8'h54);
    wait_rsp(n0, "fun_rsp");
    check("fun_b0", txb(0), 8'hDD);
    check("fun_b1", txb(1), 8'h09);
    check("fun_tmo", rsp_tmo_l, 1);
    check("fun_data", rsp_data_l, 16'h0000);
    check("fun_lat", 32'((rsp_cyc_l - rx_cyc_l >= 20) && (rsp_cyc_l - rx_cyc_l <= 22)), 1);
    step();

    // Stray RX in IDLE, then reset in the middle of an ALU frame
    n0 = rsp_cnt;
    send_rx(8'h99);
    step();
    check("stray_idle_rsp", rsp_cnt - n0, 0);
    check("stray_idle_ready", Cmd_ready, 1);
    issue(2'd2, 4'd0, 8'h11, 8'h22, 4'd3);
    step();
    RST = 1'b1;
    step();
    check("midrst_ready", Cmd_ready, 1);
    check("midrst_txv", TX_valid, 0);
    RST = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("midrst_no_rsp", rsp_cnt - n0, 0);

    // Recovery read after reset
    clr(); n0 = rsp_cnt;
    issue(2'd1, 4'd3, 8'h00, 8'h00, 4'd0);
    wait_tx(2, "rec_tx_cnt");
    step();
    send_rx(8'h5A);
    wait_rsp(n0, "rec_rsp");
    check("rec_b1", txb(1), 8'h03);
    check("rec_data", rsp_data_l, 16'h005A);
    step();

`ifdef UART_CMD_MASTER_WR_VERIFY_EN
    // Write-verify miscompare
    clr(); n0 = rsp_cnt;
    issue(2'd0, 4'd7, 8'h3C, 8'h00, 4'd0);
    wait_tx(5, "wv_tx_cnt");
    step();
    send_rx(8'h3D);
    wait_rsp(n0, "wv_rsp");
    check("wv_b0", txb(0), 8'hAA);
    check("wv_b1", txb(1), 8'h07);
    check("wv_b2", txb(2), 8'h3C);
    check("wv_b3", txb(3), 8'hBB);
    check("wv_b4", txb(4), 8'h07);
    check("wv_mm", rsp_mm_l, 1);
    check("wv_data", rsp_data_l, 16'h003D);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
